// File: rtl/usb1_pkg.sv
// usb1_pkg: shared USB 1.1 CRC5 widths and constants
package usb1_pkg;
    localparam int CRC5_W = 5;
    localparam int CRC5_DW = 11;
    localparam logic [CRC5_W-1:0] CRC5_INIT = 5'h1f;
    localparam logic [CRC5_W-1:0] CRC5_RESIDUAL = 5'b01100;
endpackage

// File: rtl/usb1_crc5_comb.sv
// usb1_crc5_comb: parallel CRC5 (x^5+x^2+1) XOR network folding 11 payload bits in one step
//   crc_in  [4:0]  current CRC state
//   din     [10:0] payload bits
//   crc_out [4:0]  next CRC state
module usb1_crc5_comb
    import usb1_pkg::*;
(
    input  logic [CRC5_W-1:0]  crc_in,
    input  logic [CRC5_DW-1:0] din,
    output logic [CRC5_W-1:0]  crc_out
);
    assign crc_out[0] = ^{din[10], din[9], din[6], din[5], din[3], din[0], crc_in[0], crc_in[3], crc_in[4]};
    assign crc_out[1] = ^{din[10], din[7], din[6], din[4], din[1], crc_in[0], crc_in[1], crc_in[4]};
    assign crc_out[2] = ^{din[10], din[9], din[8], din[7], din[6], din[3], din[2], din[0], crc_in};
    assign crc_out[3] = ^{din[10], din[9], din[8], din[7], din[4], din[3], din[1], crc_in[4:1]};
    assign crc_out[4] = ^{din[10], din[9], din[8], din[5], din[4], din[2], crc_in[4:2]};
endmodule

// File: rtl/usb1_crc5.sv
// usb1_crc5: USB 1.1 CRC5 next-state with a valid-qualified registered copy and match flag
//   clk, rst       clock, synchronous active-low reset
//   crc_in, din    CRC state and 11-bit payload
//   in_valid, chk  qualifier for the register stage, expected CRC
//   crc_out        combinational next state
//   crc_q, match_q registered next state and (crc_out == chk), held while in_valid=0
//   out_valid      strobe for crc_q/match_q
module usb1_crc5
    import usb1_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [CRC5_W-1:0]  crc_in,
    input  logic [CRC5_DW-1:0] din,
    input  logic               in_valid,
    input  logic [CRC5_W-1:0]  chk,
    output logic [CRC5_W-1:0]  crc_out,
    output logic [CRC5_W-1:0]  crc_q,
    output logic               out_valid,
    output logic               match_q
);
    logic [CRC5_W-1:0] crc_d;
    logic              match_d;

    usb1_crc5_comb u_comb (
        .crc_in  (crc_in),
        .din     (din),
        .crc_out (crc_out)
    );

    always_comb begin
        crc_d   = in_valid ? crc_out : crc_q;
        match_d = in_valid ? (crc_out == chk) : match_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            crc_q     <= '0;
            match_q   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            crc_q     <= crc_d;
            match_q   <= match_d;
            out_valid <= in_valid;
        end
    end
endmodule

// File: tb/tb_usb1_crc5.sv
// tb_usb1_crc5: vector table, corner sequences and random checks against a bit-serial CRC5 model
module tb_usb1_crc5;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  crc_in = '0;
    logic [10:0] din = '0;
    logic        in_valid = 1'b0;
    logic [4:0]  chk = '0;
    logic [4:0]  crc_out, crc_q;
    logic        out_valid, match_q;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct {
        logic [4:0]  c;
        logic [10:0] d;
        logic [4:0]  k;
        logic [4:0]  exp_crc;
        logic        exp_match;
    } vec_t;

    vec_t vecs[5];

    usb1_crc5 dut (
        .clk       (clk),
        .rst       (rst),
        .crc_in    (crc_in),
        .din       (din),
        .in_valid  (in_valid),
        .chk       (chk),
        .crc_out   (crc_out),
        .crc_q     (crc_q),
        .out_valid (out_valid),
        .match_q   (match_q)
    );

    always #5 clk = ~clk;

    // Serial LFSR, high-order payload bit shifted in first.
    function automatic logic [4:0] ref_crc(input logic [4:0] c, input logic [10:0] d);
        logic [4:0] s;
        logic       fb;
        s = c;
        for (int i = 10; i >= 0; i--) begin
            fb = s[4] ^ d[i];
            s = {s[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic v, input logic [4:0] c, input logic [10:0] d, input logic [4:0] k);
        rst = r;
        in_valid = v;
        crc_in = c;
        din = d;
        chk = k;
    endtask

    initial begin
        logic [4:0] e_crc;
        logic       e_match, e_valid;
        vecs[0] = '{5'b00000, 11'b00000000000, 5'b00000, 5'b00000, 1'b1};
        vecs[1] = '{5'b00000, 11'b10101010101, 5'b01111, 5'b01111, 1'b1};
        vecs[2] = '{5'b11100, 11'b00001111111, 5'b00000, 5'b00100, 1'b0};
        vecs[3] = '{5'b00011, 11'b00001101010, 5'b11000, 5'b11000, 1'b1};
        vecs[4] = '{5'b00011, 11'b00001101010, 5'b11001, 5'b11000, 1'b0};

        drive(1'b0, 1'b0, 5'h1f, 11'h7ff, 5'h00);
        tick();
        tick();
        check("reset crc_q", crc_q, 5'b00000);
        check("reset match_q", {4'b0, match_q}, 5'd0);
        check("reset out_valid", {4'b0, out_valid}, 5'd0);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, vecs[i].c, vecs[i].d, vecs[i].k);
            #1;
            check($sformatf("vec%0d crc_out", i), crc_out, vecs[i].exp_crc);
            tick();
            check($sformatf("vec%0d crc_q", i), crc_q, vecs[i].exp_crc);
            check($sformatf("vec%0d match_q", i), {4'b0, match_q}, {4'b0, vecs[i].exp_match});
            check($sformatf("vec%0d out_valid", i), {4'b0, out_valid}, 5'd1);
        end

        drive(1'b1, 1'b0, 5'b10101, 11'h5a5, 5'b11000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold%0d crc_q", i), crc_q, 5'b11000);
            check($sformatf("hold%0d match_q", i), {4'b0, match_q}, 5'd0);
            check($sformatf("hold%0d out_valid", i), {4'b0, out_valid}, 5'd0);
        end

        drive(1'b0, 1'b1, 5'b00011, 11'b00001101010, 5'b11000);
        #1;
        check("rst crc_out comb", crc_out, 5'b11000);
        tick();
        check("rst+valid crc_q", crc_q, 5'b00000);
        check("rst+valid match_q", {4'b0, match_q}, 5'd0);
        check("rst+valid out_valid", {4'b0, out_valid}, 5'd0);

        drive(1'b1, 1'b1, 5'b00000, 11'b10101010101, 5'b01111);
        tick();
        check("stream out_valid", {4'b0, out_valid}, 5'd1);
        rst = 1'b0;
        tick();
        check("midrst out_valid", {4'b0, out_valid}, 5'd0);
        check("midrst crc_q", crc_q, 5'b00000);
        rst = 1'b1;
        in_valid = 1'b0;
        tick();

        e_crc = crc_q === 5'b00000 ? 5'b00000 : 5'bxxxxx;
        e_crc = 5'b00000;
        e_match = 1'b0;
        e_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            logic [4:0] c, k, m;
            logic [10:0] d;
            logic r, v;
            c = 5'($urandom);
            d = 11'($urandom);
            r = ($urandom_range(0, 15) != 0);
            v = ($urandom_range(0, 3) != 0);
            m = ref_crc(c, d);
            k = ($urandom_range(0, 1) != 0) ? m : 5'($urandom);
            drive(r, v, c, d, k);
            #1;
            check("rand crc_out", crc_out, m);
            if (!r) begin
                e_crc = 5'b00000;
                e_match = 1'b0;
                e_valid = 1'b0;
            end else begin
                e_valid = v;
                if (v) begin
                    e_crc = m;
                    e_match = (m == k);
                end
            end
            tick();
            check("rand crc_q", crc_q, e_crc);
            check("rand match_q", {4'b0, match_q}, {4'b0, e_match});
            check("rand out_valid", {4'b0, out_valid}, {4'b0, e_valid});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
